// File: rtl/exception_sequencer_if.sv
// Signal bundle between the writeback stage, CP0 and fetch redirect logic
// and the exception sequencer. The sequencer uses the slave modport.
interface exception_sequencer_if;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_exception;
  logic [4:0]  wb_exception_code;
  logic        wb_is_eret;
  logic [31:0] wb_pc;
  logic        wb_in_delay_slot;
  logic [31:0] wb_badvaddr;
  logic [7:0]  interrupt_pending;
  logic [31:0] cp0_epc;

  logic        cp0_exception_valid;
  logic        cp0_eret_flush;
  logic        cp0_is_address_fault;
  logic [4:0]  cp0_exception_code;
  logic [31:0] cp0_exception_address;
  logic [31:0] cp0_badvaddr;
  logic        cp0_in_delay_slot;

  logic        pipeline_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport master (
    output wb_valid, wb_exception, wb_exception_code, wb_is_eret, wb_pc,
           wb_in_delay_slot, wb_badvaddr, interrupt_pending, cp0_epc,
           redirect_ready,
    input  wb_ready, cp0_exception_valid, cp0_eret_flush, cp0_is_address_fault,
           cp0_exception_code, cp0_exception_address, cp0_badvaddr,
           cp0_in_delay_slot, pipeline_flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  wb_valid, wb_exception, wb_exception_code, wb_is_eret, wb_pc,
           wb_in_delay_slot, wb_badvaddr, interrupt_pending, cp0_epc,
           redirect_ready,
    output wb_ready, cp0_exception_valid, cp0_eret_flush, cp0_is_address_fault,
           cp0_exception_code, cp0_exception_address, cp0_badvaddr,
           cp0_in_delay_slot, pipeline_flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_sequencer.sv
// Commits interrupts/exceptions/ERET from WB to CP0, flushes the pipeline for
// a fixed number of cycles, then hands the new PC to fetch.
module exception_sequencer #(
  parameter logic [31:0] EXCEPTION_VECTOR = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  exception_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  state_t      state, next_state;
  logic [3:0]  count, next_count;
  logic [31:0] target, next_target;

  logic take_interrupt;
  logic take_exception;
  logic take_eret;
  logic accept;
  logic address_fault_code;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      target <= '0;
    end else begin
      state  <= next_state;
      count  <= next_count;
      target <= next_target;
    end
  end

  // NOTE: every output and next-state value gets a default first, so no path
  // through the case can leave one unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    next_count  = count;
    next_target = target;

    bus.wb_ready              = 1'b0;
    bus.cp0_exception_valid   = 1'b0;
    bus.cp0_eret_flush        = 1'b0;
    bus.cp0_is_address_fault  = 1'b0;
    bus.cp0_exception_code    = 5'h00;
    bus.cp0_exception_address = 32'h0;
    bus.cp0_badvaddr          = 32'h0;
    bus.cp0_in_delay_slot     = 1'b0;
    bus.pipeline_flush        = 1'b0;
    bus.redirect_valid        = 1'b0;
    bus.redirect_pc           = 32'h0;

    // Fixed priority: interrupt, then synchronous exception, then ERET.
    take_interrupt     = |bus.interrupt_pending;
    take_exception     = !take_interrupt && bus.wb_exception;
    take_eret          = !take_interrupt && !bus.wb_exception && bus.wb_is_eret;
    address_fault_code = (bus.wb_exception_code == 5'h04) ||
                         (bus.wb_exception_code == 5'h05);
    accept             = 1'b0;

    if (!reset) begin
      unique case (state)
        IDLE: begin
          bus.wb_ready = 1'b1;
          accept = bus.wb_valid && (take_interrupt || take_exception || take_eret);
          if (accept) begin
            bus.pipeline_flush = 1'b1;
            next_state         = FLUSH;
            next_count         = 4'(FLUSH_CYCLES - 1);
            if (take_eret) begin
              bus.cp0_eret_flush = 1'b1;
              next_target        = bus.cp0_epc;
            end else begin
              bus.cp0_exception_valid   = 1'b1;
              bus.cp0_exception_code    = take_interrupt ? 5'h00 : bus.wb_exception_code;
              bus.cp0_exception_address = bus.wb_pc;
              bus.cp0_in_delay_slot     = bus.wb_in_delay_slot;
              if (take_exception && address_fault_code) begin
                bus.cp0_is_address_fault = 1'b1;
                bus.cp0_badvaddr         = bus.wb_badvaddr;
              end
              next_target = EXCEPTION_VECTOR;
            end
          end
        end

        FLUSH: begin
          bus.pipeline_flush = 1'b1;
          if (count == 4'd0) next_state = REDIRECT;
          else               next_count = count - 4'd1;
        end

        REDIRECT: begin
          bus.redirect_valid = 1'b1;
          bus.redirect_pc    = target;
          if (bus.redirect_ready) next_state = IDLE;
        end

        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed and random stimulus for exception_sequencer, checked every cycle
// against a cycle-count reference model of the commit/flush/redirect sequence.
module tb_exception_sequencer;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam int          F   = 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  exception_sequencer_if bus();

  exception_sequencer #(
    .EXCEPTION_VECTOR (VEC),
    .FLUSH_CYCLES     (F)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: remaining flush cycles after acceptance, pending redirect, target.
  int          flush_left       = 0;
  bit          redirect_pending = 1'b0;
  logic [31:0] model_target     = 32'h0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle_inputs();
    bus.wb_valid          = 1'b0;
    bus.wb_exception      = 1'b0;
    bus.wb_exception_code = 5'h00;
    bus.wb_is_eret        = 1'b0;
    bus.wb_pc             = 32'h0;
    bus.wb_in_delay_slot  = 1'b0;
    bus.wb_badvaddr       = 32'h0;
    bus.interrupt_pending = 8'h00;
    bus.cp0_epc           = 32'h0;
    bus.redirect_ready    = 1'b0;
  endtask

  // Called just after a posedge with inputs set; checks this cycle, advances one clock.
  task automatic tick();
    logic        exp_ready, exp_ev, exp_eret, exp_flush, exp_af, exp_rv, exp_ds;
    logic [4:0]  exp_code;
    logic [31:0] exp_addr, exp_bad, exp_rpc;
    bit          idle, is_int, is_exc, is_eret, accepted;

    #2;
    exp_ready = 0; exp_ev = 0; exp_eret = 0; exp_flush = 0; exp_af = 0;
    exp_rv = 0; exp_ds = 0; exp_code = 5'h00; exp_addr = 32'h0;
    exp_bad = 32'h0; exp_rpc = 32'h0;

    idle     = (flush_left == 0) && !redirect_pending;
    is_int   = (bus.interrupt_pending != 8'h00);
    is_exc   = !is_int && bus.wb_exception;
    is_eret  = !is_int && !bus.wb_exception && bus.wb_is_eret;
    accepted = !reset && idle && bus.wb_valid && (is_int || is_exc || is_eret);

    if (!reset) begin
      exp_ready = idle;
      exp_flush = accepted || (flush_left > 0);
      if (redirect_pending) begin
        exp_rv  = 1'b1;
        exp_rpc = model_target;
      end
      if (accepted && is_eret) exp_eret = 1'b1;
      if (accepted && !is_eret) begin
        exp_ev   = 1'b1;
        exp_code = is_int ? 5'h00 : bus.wb_exception_code;
        exp_addr = bus.wb_pc;
        exp_ds   = bus.wb_in_delay_slot;
        if (is_exc && (bus.wb_exception_code inside {5'h04, 5'h05})) begin
          exp_af  = 1'b1;
          exp_bad = bus.wb_badvaddr;
        end
      end
    end

    check("wb_ready",        32'(bus.wb_ready),              32'(exp_ready));
    check("exception_valid", 32'(bus.cp0_exception_valid),   32'(exp_ev));
    check("eret_flush",      32'(bus.cp0_eret_flush),        32'(exp_eret));
    check("address_fault",   32'(bus.cp0_is_address_fault),  32'(exp_af));
    check("exception_code",  32'(bus.cp0_exception_code),    32'(exp_code));
    check("exception_addr",  bus.cp0_exception_address,      exp_addr);
    check("badvaddr",        bus.cp0_badvaddr,               exp_bad);
    check("in_delay_slot",   32'(bus.cp0_in_delay_slot),     32'(exp_ds));
    check("pipeline_flush",  32'(bus.pipeline_flush),        32'(exp_flush));
    check("redirect_valid",  32'(bus.redirect_valid),        32'(exp_rv));
    check("redirect_pc",     bus.redirect_pc,                exp_rpc);

    if (reset) begin
      flush_left       = 0;
      redirect_pending = 1'b0;
      model_target     = 32'h0;
    end else if (accepted) begin
      flush_left   = F;
      model_target = is_eret ? bus.cp0_epc : VEC;
    end else if (flush_left > 0) begin
      flush_left--;
      if (flush_left == 0) redirect_pending = 1'b1;
    end else if (redirect_pending && bus.redirect_ready) begin
      redirect_pending = 1'b0;
    end

    @(posedge clock);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Reset holds everything quiet even with an event presented.
    bus.wb_valid = 1'b1;
    bus.interrupt_pending = 8'h01;
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    tick();

    // Address-error exception: one strobe, three flush cycles, vector redirect.
    bus.wb_valid          = 1'b1;
    bus.wb_exception      = 1'b1;
    bus.wb_exception_code = 5'h04;
    bus.wb_pc             = 32'h8000_0010;
    bus.wb_badvaddr       = 32'h0000_1233;
    tick();
    idle_inputs();
    repeat (F) tick();
    tick();
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    tick();

    // ERET; redirect_ready during flush must be ignored.
    bus.wb_valid   = 1'b1;
    bus.wb_is_eret = 1'b1;
    bus.cp0_epc    = 32'h8000_0100;
    tick();
    idle_inputs();
    bus.redirect_ready = 1'b1;
    repeat (F) tick();
    tick();
    bus.redirect_ready = 1'b0;
    tick();

    // Interrupt beats a same-cycle exception and ERET.
    bus.wb_valid          = 1'b1;
    bus.interrupt_pending = 8'h80;
    bus.wb_exception      = 1'b1;
    bus.wb_exception_code = 5'h0A;
    bus.wb_is_eret        = 1'b1;
    bus.wb_pc             = 32'h8000_0200;
    bus.wb_in_delay_slot  = 1'b1;
    tick();
    // A new interrupt while busy waits; redirect is stalled for five cycles.
    idle_inputs();
    bus.wb_valid          = 1'b1;
    bus.interrupt_pending = 8'h04;
    bus.wb_pc             = 32'h8000_0300;
    repeat (F) tick();
    repeat (5) tick();
    bus.redirect_ready = 1'b1;
    tick();
    bus.redirect_ready = 1'b0;
    tick();

    // Reset in the middle of FLUSH, then a plain instruction.
    idle_inputs();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    bus.wb_valid = 1'b1;
    bus.wb_pc    = 32'h8000_0400;
    tick();
    idle_inputs();
    tick();

    // Random traffic including occasional resets.
    for (int i = 0; i < 400; i++) begin
      bus.wb_valid          = 1'($urandom % 2);
      bus.interrupt_pending = ($urandom % 6 == 0) ? 8'($urandom) : 8'h00;
      bus.wb_exception      = ($urandom % 4 == 0);
      bus.wb_exception_code = ($urandom % 2 == 1) ? 5'(4 + $urandom % 2) : 5'($urandom);
      bus.wb_is_eret        = ($urandom % 5 == 0);
      bus.wb_pc             = $urandom;
      bus.wb_in_delay_slot  = 1'($urandom % 2);
      bus.wb_badvaddr       = $urandom;
      bus.cp0_epc           = $urandom;
      bus.redirect_ready    = ($urandom % 3 == 0);
      reset                 = ($urandom % 50 == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exception_sequencer.md
EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 SHALL have parameter EXCEPTION_VECTOR, 32'hBFC00380, handler entry PC.
REQ-002 SHALL have parameter FLUSH_CYCLES, 2, cycles pipeline_flush is held (legal 1..15).
REQ-003 clock  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 wb_valid  input  1  instruction present in WB this cycle.
REQ-006 wb_ready  output  1  sequencer accepts the WB instruction this cycle.
REQ-007 wb_exception  input  1  WB instruction carries a synchronous exception.
REQ-008 wb_exception_code  input  5  ExcCode of that exception.
REQ-009 wb_is_eret  input  1  WB instruction is ERET.
REQ-010 wb_pc  input  32  PC of the WB instruction.
REQ-011 wb_in_delay_slot  input  1  WB instruction is in a branch delay slot.
REQ-012 wb_badvaddr  input  32  faulting address for address errors.
REQ-013 interrupt_pending  input  8  masked/enabled interrupt lines from CP0.
REQ-014 cp0_epc  input  32  current EPC value from CP0.
REQ-015 cp0_exception_valid, cp0_eret_flush, cp0_is_address_fault  output  1 each  CP0 commit strobes.
REQ-016 cp0_exception_code  output  5; cp0_exception_address, cp0_badvaddr  output  32; cp0_in_delay_slot  output  1  CP0 commit data.
REQ-017 pipeline_flush  output  1  kill all in-flight IF..WB instructions.
REQ-018 redirect_valid  output  1; redirect_pc  output  32; redirect_ready  input  1  fetch redirect handshake.

Function
REQ-019 SHALL implement states IDLE, FLUSH, REDIRECT.
REQ-020 wb_ready SHALL be 1 only in IDLE; WB inputs SHALL be ignored outside IDLE.
REQ-021 In IDLE, an event SHALL be taken when wb_valid=1 and (|interrupt_pending or wb_exception or wb_is_eret).
REQ-022 Priority SHALL be interrupt > synchronous exception > ERET; only one event per acceptance.
REQ-023 Interrupt: code 5'h00, address wb_pc, in_delay_slot from WB, is_address_fault=0.
REQ-024 Exception: code wb_exception_code; is_address_fault=1 iff code is 5'h04 or 5'h05, then cp0_badvaddr=wb_badvaddr, else cp0_badvaddr=0.
REQ-025 On interrupt/exception, cp0_exception_valid SHALL pulse exactly one cycle, combinationally in the acceptance cycle, with commit data valid that cycle.
REQ-026 On ERET, cp0_eret_flush SHALL pulse one cycle in the acceptance cycle; cp0_exception_valid SHALL stay 0.
REQ-027 Redirect target SHALL be latched at acceptance: EXCEPTION_VECTOR for interrupt/exception, cp0_epc sampled that cycle for ERET.
REQ-028 On acceptance, next state SHALL be FLUSH with flush counter loaded to FLUSH_CYCLES-1.
REQ-029 pipeline_flush SHALL be 1 in the acceptance cycle and every FLUSH cycle (FLUSH_CYCLES+1 cycles total).
REQ-030 FLUSH SHALL decrement the counter each cycle and go to REDIRECT the cycle after it reads 0.
REQ-031 In REDIRECT, redirect_valid=1 and redirect_pc=latched target, held stable until redirect_ready=1; then IDLE next cycle.
REQ-032 redirect_ready while redirect_valid=0 SHALL have no effect.
REQ-033 Normal instruction (wb_valid=1, no event) SHALL cause no strobe, no flush, stay IDLE.
REQ-034 Interrupt arriving outside IDLE SHALL not be taken until IDLE with wb_valid=1.
REQ-035 All CP0 commit outputs SHALL be 0 whenever no event is accepted.

Reset
REQ-036 reset SHALL force IDLE, counter 0, latched target 0, from any state including mid-FLUSH/REDIRECT.
REQ-037 While reset=1 all strobes, pipeline_flush and redirect_valid SHALL be 0; wb_ready=0.

Verification
REQ-038 wb_valid=1, wb_exception=1, code 5'h04, wb_pc=32'h8000_0010, badvaddr=32'h1233 -> exception_valid 1 cycle, is_address_fault=1, badvaddr 32'h1233, flush 3 cycles, redirect_pc 32'hBFC00380.
REQ-039 wb_is_eret=1, cp0_epc=32'h8000_0100 -> eret_flush 1 cycle, exception_valid 0, redirect_pc 32'h8000_0100.
REQ-040 interrupt_pending=8'h80 with wb_exception=1 code 5'h0A same cycle -> exception_code 5'h00, single exception_valid.
REQ-041 redirect_ready=0 for 5 cycles in REDIRECT -> redirect_valid/redirect_pc stable, wb_ready=0; ready=1 -> IDLE next cycle.
REQ-042 reset asserted during FLUSH -> next cycle IDLE, all outputs 0; post-reset normal instruction causes no strobe.
